// File: rtl/vrf_operand_fetch.sv
// Read-side sequencer for the banked vector register file: issues one beat per
// cycle across all banks, buffers returned data in a 3-entry FIFO and streams it out.
module vrf_operand_fetch #(
   parameter int NumVRs     = 32,
   parameter int ElemsPerVR = 32,
   parameter int NumBanks   = 4,
   parameter int DataWidth  = 32,
   localparam int WordsPerBank = NumVRs * ElemsPerVR / NumBanks,
   localparam int AddrWidth    = $clog2(WordsPerBank),
   localparam int BeatsPerVR   = ElemsPerVR / NumBanks,
   localparam int VregWidth    = $clog2(NumVRs),
   localparam int BeatWidth    = $clog2(BeatsPerVR),
   localparam int BeatDataW    = NumBanks * DataWidth
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          req_valid,
   output logic                          req_ready,
   input  logic [VregWidth-1:0]          req_vreg,
   output logic [NumBanks-1:0]           re,
   output logic [NumBanks*AddrWidth-1:0] r_addr,
   input  logic [BeatDataW-1:0]          rdata,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [BeatDataW-1:0]          out_data,
   output logic [BeatWidth-1:0]          out_beat,
   output logic                          out_last,
   output logic                          busy
);

   localparam int FifoDepth = 3;
   localparam logic [BeatWidth-1:0] LastBeat = BeatWidth'(BeatsPerVR - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

   state_t                 state, state_next;
   logic [VregWidth-1:0]   vreg_q;
   logic [BeatWidth-1:0]   beat_cnt;
   logic [AddrWidth-1:0]   issue_addr, addr_hold;
   logic                   issue, issue_last;
   logic                   inflight, inflight_last;
   logic [BeatWidth-1:0]   inflight_beat;

   logic [BeatDataW-1:0]   fifo_data [FifoDepth];
   logic [BeatWidth-1:0]   fifo_beat [FifoDepth];
   logic                   fifo_last [FifoDepth];
   logic [1:0]             wr_ptr, rd_ptr, fifo_count;
   logic [2:0]             credits_used;
   logic                   push, pop, head_last;

   function automatic logic [1:0] ptr_inc(input logic [1:0] p);
      return (p == 2'(FifoDepth - 1)) ? 2'd0 : p + 2'd1;
   endfunction

   assign issue_addr   = AddrWidth'(vreg_q) * AddrWidth'(BeatsPerVR) + AddrWidth'(beat_cnt);
   assign issue_last   = (beat_cnt == LastBeat);
   // Beats already in the FIFO plus the one in the VRF pipeline count against capacity.
   assign credits_used = 3'(fifo_count) + 3'(inflight);

   always_comb begin
      state_next = state;
      req_ready  = 1'b0;
      issue      = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_next = ISSUE;
         end
         ISSUE: begin
            if (credits_used < 3'(FifoDepth)) begin
               issue = 1'b1;
               if (issue_last) state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (pop && head_last) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vreg_q    <= '0;
         beat_cnt  <= '0;
         addr_hold <= '0;
      end else if (state == IDLE && req_valid) begin
         vreg_q   <= req_vreg;
         beat_cnt <= '0;
      end else if (issue) begin
         beat_cnt  <= beat_cnt + BeatWidth'(1);
         addr_hold <= issue_addr;
      end
   end

   // Tags travel alongside the VRF read so the returned data can be labelled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inflight      <= 1'b0;
         inflight_beat <= '0;
         inflight_last <= 1'b0;
      end else begin
         inflight      <= issue;
         inflight_beat <= beat_cnt;
         inflight_last <= issue_last;
      end
   end

   assign re     = {NumBanks{issue}};
   assign r_addr = {NumBanks{issue ? issue_addr : addr_hold}};

   assign push = inflight;
   assign pop  = out_valid && out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + 2'd1;
            2'b01:   fifo_count <= fifo_count - 2'd1;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data[wr_ptr] <= rdata;
         fifo_beat[wr_ptr] <= inflight_beat;
         fifo_last[wr_ptr] <= inflight_last;
      end
   end

   assign out_valid = (fifo_count != 2'd0);
   assign head_last = fifo_last[rd_ptr];
   assign out_data  = out_valid ? fifo_data[rd_ptr] : '0;
   assign out_beat  = out_valid ? fifo_beat[rd_ptr] : '0;
   assign out_last  = out_valid && head_last;
   assign busy      = (state != IDLE) || out_valid;

endmodule

// File: tb/tb_vrf_operand_fetch.sv
// Self-checking bench for vrf_operand_fetch: a VRF model answers reads from an
// element-level image of every vector register; beats are compared against it.
module tb_vrf_operand_fetch;

   localparam int NB  = 4;
   localparam int DW  = 32;
   localparam int AW  = 8;
   localparam int BPV = 8;
   localparam int NVR = 32;
   localparam int EPV = 32;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               req_valid = 1'b0;
   logic               req_ready;
   logic [4:0]         req_vreg = '0;
   logic [NB-1:0]      re;
   logic [NB*AW-1:0]   r_addr;
   logic [NB*DW-1:0]   rdata = '0;
   logic               out_valid;
   logic               out_ready = 1'b1;
   logic [NB*DW-1:0]   out_data;
   logic [2:0]         out_beat;
   logic               out_last;
   logic               busy;

   vrf_operand_fetch dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_vreg  (req_vreg),
      .re        (re),
      .r_addr    (r_addr),
      .rdata     (rdata),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_beat  (out_beat),
      .out_last  (out_last),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Element-level image of the register file: element e of VR v.
   logic [31:0] vr_elem [NVR][EPV];

   function automatic logic [31:0] vrf_word(input int bank, input int word);
      return vr_elem[word / BPV][(word % BPV) * NB + bank];
   endfunction

   function automatic logic [NB*DW-1:0] exp_beat(input int v, input int b);
      logic [NB*DW-1:0] res;
      for (int i = 0; i < NB; i++) res[i*DW +: DW] = vr_elem[v][b*NB + i];
      return res;
   endfunction

   always @(posedge clk)
      for (int i = 0; i < NB; i++)
         rdata[i*DW +: DW] <= re[i] ? vrf_word(i, int'(r_addr[i*AW +: AW])) : 32'h0;

   int               total = 0;
   int               bad = 0;
   int               iss_cyc[$];
   int               iss_addr[$];
   bit               iss_ok[$];
   int               out_cyc[$];
   logic [NB*DW-1:0] out_dq[$];
   int               out_bq[$];
   bit               out_lq[$];
   int               rr_rise[$];
   int               iss_total = 0;
   int               pop_total = 0;
   int               max_out = 0;
   int               stable_err = 0;
   bit               mon_ok;
   bit               prev_rr = 1'b0;
   bit               prev_stall = 1'b0;
   logic [NB*DW-1:0] prev_data;
   logic [2:0]       prev_beat;
   logic             prev_last;

   // Passive monitor: records issues, accepted beats and req_ready rises.
   always @(negedge clk) begin
      if (rst) begin
         iss_total  = 0;
         pop_total  = 0;
         prev_stall = 1'b0;
         prev_rr    = 1'b0;
      end else begin
         if (re != '0) begin
            mon_ok = (re == 4'hF);
            for (int i = 1; i < NB; i++)
               if (r_addr[i*AW +: AW] != r_addr[AW-1:0]) mon_ok = 1'b0;
            iss_cyc.push_back(cyc);
            iss_addr.push_back(int'(r_addr[AW-1:0]));
            iss_ok.push_back(mon_ok);
            iss_total++;
         end
         if (iss_total - pop_total > max_out) max_out = iss_total - pop_total;
         if (prev_stall && !(out_valid && out_data == prev_data &&
                             out_beat == prev_beat && out_last == prev_last))
            stable_err++;
         if (out_valid && out_ready) begin
            out_cyc.push_back(cyc);
            out_dq.push_back(out_data);
            out_bq.push_back(int'(out_beat));
            out_lq.push_back(out_last);
            pop_total++;
         end
         if (req_ready && !prev_rr) rr_rise.push_back(cyc);
         prev_rr    = req_ready;
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         prev_beat  = out_beat;
         prev_last  = out_last;
      end
   end

   task automatic checkOutput(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic checkData(input string name, input logic [NB*DW-1:0] act,
                            input logic [NB*DW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic clearQueues();
      iss_cyc.delete(); iss_addr.delete(); iss_ok.delete();
      out_cyc.delete(); out_dq.delete(); out_bq.delete(); out_lq.delete();
      rr_rise.delete();
   endtask

   task automatic applyStimulus(input int v, output int t0);
      t0 = -1;
      @(posedge clk); #1;
      req_valid = 1'b1;
      req_vreg  = 5'(v);
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (req_ready) begin
            t0 = cyc;
            break;
         end
      end
      if (t0 < 0) checkOutput("request handshake timeout", 0, 1);
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic waitDone(input bit rnd);
      bit done = 1'b0;
      for (int n = 0; n < 400; n++) begin
         @(posedge clk); #1;
         if (rnd) out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (!busy) begin
            done = 1'b1;
            break;
         end
      end
      if (!done) checkOutput("busy drop timeout", 0, 1);
      @(posedge clk); #1;
      out_ready = 1'b1;
   endtask

   // Pops one read's worth (8 issues, 8 beats) from the monitor queues and checks it.
   task automatic checkRead(input string tag, input int v, input int base, input bit exact,
                            input int t0, input int exp_out0, input int exp_ready,
                            input int exp_left, output int last_a);
      int a, c, b, rise;
      bit ok, l;
      logic [NB*DW-1:0] d;
      last_a = -1;
      checkOutput($sformatf("%s issue count", tag), int'(iss_addr.size() >= BPV), 1);
      checkOutput($sformatf("%s beat count", tag), int'(out_dq.size() >= BPV), 1);
      for (int k = 0; k < BPV; k++) begin
         if (iss_addr.size() > 0) begin
            a = iss_addr.pop_front();
            c = iss_cyc.pop_front();
            ok = iss_ok.pop_front();
            last_a = a;
            checkOutput($sformatf("%s addr%0d", tag, k), a, base + k);
            checkOutput($sformatf("%s re all banks%0d", tag, k), int'(ok), 1);
            if (exact) checkOutput($sformatf("%s issue cycle%0d", tag, k), c - t0, 1 + k);
         end
         if (out_dq.size() > 0) begin
            d = out_dq.pop_front();
            b = out_bq.pop_front();
            l = out_lq.pop_front();
            c = out_cyc.pop_front();
            checkData($sformatf("%s data%0d", tag, k), d, exp_beat(v, k));
            checkOutput($sformatf("%s beat%0d", tag, k), b, k);
            checkOutput($sformatf("%s last%0d", tag, k), int'(l), int'(k == BPV - 1));
            if (exact) checkOutput($sformatf("%s out cycle%0d", tag, k), c - t0, exp_out0 + k);
         end
      end
      if (exact) begin
         rise = -1;
         foreach (rr_rise[j]) if (rise < 0 && rr_rise[j] > t0) rise = rr_rise[j];
         checkOutput($sformatf("%s req_ready cycle", tag), rise - t0, exp_ready);
      end
      checkOutput($sformatf("%s leftover issues", tag), iss_addr.size(), exp_left);
      checkOutput($sformatf("%s leftover beats", tag), out_dq.size(), exp_left);
   endtask

   typedef struct {
      int vreg;
      int first_addr;
      int last_addr;
      int first_out;
      int ready_rel;
   } vec_t;

   vec_t tbl[4];

   initial begin
      int t0, t0b, la, v;
      tbl[0] = '{5, 40, 47, 3, 11};
      tbl[1] = '{0, 0, 7, 3, 11};
      tbl[2] = '{17, 136, 143, 3, 11};
      tbl[3] = '{30, 240, 247, 3, 11};
      for (int vr = 0; vr < NVR; vr++)
         for (int e = 0; e < EPV; e++)
            vr_elem[vr][e] = (vr == 31) ? 32'h1000 + 32'(e) : $urandom;

      // Reset state
      repeat (3) @(negedge clk);
      checkOutput("reset re", int'(re), 0);
      checkOutput("reset r_addr", int'(r_addr), 0);
      checkOutput("reset out_valid", int'(out_valid), 0);
      checkData("reset out_data", out_data, '0);
      checkOutput("reset out_beat", int'(out_beat), 0);
      checkOutput("reset out_last", int'(out_last), 0);
      checkOutput("reset busy", int'(busy), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("req_ready after release", int'(req_ready), 1);

      // Table of full-rate reads with exact cycle timing
      for (int r = 0; r < 4; r++) begin
         clearQueues();
         applyStimulus(tbl[r].vreg, t0);
         waitDone(1'b0);
         checkRead($sformatf("vec%0d", r), tbl[r].vreg, tbl[r].first_addr, 1'b1, t0,
                   tbl[r].first_out, tbl[r].ready_rel, 0, la);
         checkOutput($sformatf("vec%0d last addr", r), la, tbl[r].last_addr);
      end

      // Preloaded VR31 pattern, top of the address space
      clearQueues();
      applyStimulus(31, t0);
      waitDone(1'b0);
      if (out_dq.size() > 2)
         checkData("vr31 beat2 literal", out_dq[2], 128'h0000100B_0000100A_00001009_00001008);
      else
         checkOutput("vr31 beat2 present", out_dq.size(), 3);
      checkRead("vr31", 31, 248, 1'b1, t0, 3, 11, 0, la);
      checkOutput("vr31 last addr", la, 255);

      // Downstream stalled from the start: only three beats may be issued
      clearQueues();
      max_out = 0;
      stable_err = 0;
      out_ready = 1'b0;
      applyStimulus(9, t0);
      repeat (12) @(posedge clk);
      @(negedge clk);
      checkOutput("stall issue count", iss_addr.size(), 3);
      for (int k = 0; k < 3; k++)
         if (k < iss_addr.size())
            checkOutput($sformatf("stall addr%0d", k), iss_addr[k], 72 + k);
      checkOutput("stall out_valid", int'(out_valid), 1);
      checkOutput("stall out_beat", int'(out_beat), 0);
      checkData("stall head data", out_data, exp_beat(9, 0));
      checkOutput("stall outstanding", max_out, 3);
      @(posedge clk); #1;
      out_ready = 1'b1;
      waitDone(1'b0);
      checkOutput("stall data stable", stable_err, 0);
      checkRead("stall resume", 9, 72, 1'b0, t0, 0, 0, 0, la);

      // Random downstream backpressure over 20 reads
      max_out = 0;
      stable_err = 0;
      for (int r = 0; r < 20; r++) begin
         clearQueues();
         v = int'($urandom_range(0, NVR - 1));
         applyStimulus(v, t0);
         waitDone(1'b1);
         checkRead($sformatf("rand%0d", r), v, v * BPV, 1'b0, t0, 0, 0, 0, la);
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end
      checkOutput("random fifo bound", int'(max_out <= 3), 1);
      checkOutput("random data stable", stable_err, 0);

      // Reset in the middle of a read
      clearQueues();
      applyStimulus(12, t0);
      repeat (4) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      checkOutput("midreset re", int'(re), 0);
      checkOutput("midreset out_valid", int'(out_valid), 0);
      checkOutput("midreset busy", int'(busy), 0);
      checkData("midreset out_data", out_data, '0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      clearQueues();
      repeat (6) @(negedge clk);
      checkOutput("after reset no issues", iss_addr.size(), 0);
      checkOutput("after reset no beats", out_dq.size(), 0);
      checkOutput("after reset req_ready", int'(req_ready), 1);
      clearQueues();
      applyStimulus(2, t0);
      waitDone(1'b0);
      checkRead("post reset", 2, 16, 1'b1, t0, 3, 11, 0, la);

      // req_valid held high across two back-to-back requests
      clearQueues();
      t0 = -1;
      t0b = -1;
      @(posedge clk); #1;
      req_valid = 1'b1;
      req_vreg  = 5'd0;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (req_ready) begin
            t0 = cyc;
            break;
         end
      end
      @(posedge clk); #1;
      req_vreg = 5'd1;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         if (req_ready) begin
            t0b = cyc;
            break;
         end
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      waitDone(1'b0);
      checkOutput("b2b second accept gap", t0b - t0, 11);
      checkRead("b2b first", 0, 0, 1'b1, t0, 3, 11, BPV, la);
      checkRead("b2b second", 1, 8, 1'b1, t0b, 3, 11, 0, la);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired actual=running required=finished");
      $fatal(1, "[TB] watchdog");
   end

endmodule
